// File: rtl/level_peak_hold_if.sv
// Bus bundle for the level peak-hold meter: level/strobe inward, meter outputs back.
interface level_peak_hold_if;
  logic [3:0] level;
  logic       sample;
  logic [3:0] cur;
  logic [3:0] peak;
  logic [7:0] bar;
  logic       changed;
  logic       ovf;

  modport master (
    output level, sample,
    input  cur, peak, bar, changed, ovf
  );

  modport slave (
    input  level, sample,
    output cur, peak, bar, changed, ovf
  );
endinterface

// File: rtl/level_peak_hold.sv
// Bar-graph level meter stage: captures the clamped level on a strobe and keeps a
// peak that is held for HOLD_TICKS cycles, then steps down once every DECAY_TICKS cycles.
module level_peak_hold #(
  parameter int unsigned HOLD_TICKS  = 4,
  parameter int unsigned DECAY_TICKS = 2
) (
  input  logic          clk,
  input  logic          reset,
  level_peak_hold_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DECAY = 2'd2;

  localparam logic [15:0] HOLD_RELOAD  = 16'(HOLD_TICKS - 1);
  localparam logic [15:0] DECAY_RELOAD = 16'(DECAY_TICKS - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  cur_q, cur_d;
  logic [3:0]  peak_q, peak_d;
  logic        changed_q, changed_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  v;
  logic        catch_peak;
  logic [7:0]  bar_w;

  assign v          = (bus.level > 4'd8) ? 4'd8 : bus.level;
  assign catch_peak = bus.sample && (v >= peak_q);

  always_comb begin
    cur_d     = cur_q;
    changed_d = 1'b0;
    ovf_d     = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    peak_d    = peak_q;

    if (bus.sample) begin
      cur_d     = v;
      changed_d = (v != cur_q);
      ovf_d     = (bus.level > 4'd8);
    end

    // A qualifying sample always beats the timer; otherwise the timer acts.
    case (state_q)
      ST_IDLE: begin
        if (bus.sample && (v != 4'd0)) begin
          peak_d  = v;
          cnt_d   = HOLD_RELOAD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (catch_peak) begin
          peak_d = v;
          cnt_d  = HOLD_RELOAD;
        end else if (cnt_q == 16'd0) begin
          cnt_d   = DECAY_RELOAD;
          state_d = ST_DECAY;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DECAY: begin
        if (catch_peak) begin
          peak_d  = v;
          cnt_d   = HOLD_RELOAD;
          state_d = ST_HOLD;
        end else if (cnt_q == 16'd0) begin
          peak_d = peak_q - 4'd1;
          if (peak_q == 4'd1) begin
            cnt_d   = 16'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = DECAY_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        peak_d  = 4'd0;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      cur_q     <= 4'd0;
      peak_q    <= 4'd0;
      changed_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      peak_q    <= peak_d;
      changed_q <= changed_d;
      ovf_q     <= ovf_d;
    end
  end

  // Thermometer decode straight off the peak register.
  always_comb begin
    bar_w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bar_w[i] = (4'(i) < peak_q);
    end
  end

  assign bus.cur     = cur_q;
  assign bus.peak    = peak_q;
  assign bus.bar     = bar_w;
  assign bus.changed = changed_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_level_peak_hold.sv
// Bench for level_peak_hold: directed table, corner-case sequences and random
// stimulus against an elapsed-time model of the peak-hold meter.
module tb_level_peak_hold;

  localparam int H = 4;
  localparam int D = 2;

  typedef struct {
    logic       rst;
    logic [3:0] lvl;
    logic       smp;
    logic [3:0] eCur;
    logic [3:0] ePeak;
    logic [7:0] eBar;
    logic       eChg;
    logic       eOvf;
  } vec_t;

  logic clk;
  logic reset;
  level_peak_hold_if bus ();

  level_peak_hold #(.HOLD_TICKS(H), .DECAY_TICKS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // Reference model: the peak is the last captured peak minus the number of
  // decay steps that fit in the time elapsed since it was captured.
  int         mP = 0;
  int         mE = 0;
  int         n = 0;
  logic [3:0] mCur = 4'd0;
  logic       mChg = 1'b0;
  logic       mOvf = 1'b0;

  vec_t tbl[18];

  function automatic int modelPeak(int t);
    int el;
    int steps;
    el = t - mE;
    steps = (el < H) ? 0 : (el - H) / D;
    return (mP > steps) ? (mP - steps) : 0;
  endfunction

  function automatic logic [7:0] thermo(int p);
    int m;
    m = (1 << p) - 1;
    return m[7:0];
  endfunction

  task automatic applyStimulus(input logic rst, input logic [3:0] lvl, input logic smp);
    int prevPeak;
    int v;
    @(negedge clk);
    reset      = rst;
    bus.level  = lvl;
    bus.sample = smp;
    @(posedge clk);
    n++;
    if (rst) begin
      mP = 0; mE = n; mCur = 4'd0; mChg = 1'b0; mOvf = 1'b0;
    end else begin
      prevPeak = modelPeak(n - 1);
      v = (lvl > 4'd8) ? 8 : int'(lvl);
      mChg = 1'b0;
      mOvf = 1'b0;
      if (smp) begin
        mChg = (4'(v) != mCur);
        mOvf = (lvl > 4'd8);
        mCur = 4'(v);
        if (v >= prevPeak) begin
          mP = v;
          mE = n;
        end
      end
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eCur, input logic [3:0] ePeak,
                             input logic [7:0] eBar, input logic eChg, input logic eOvf);
    tests++;
    if (bus.cur !== eCur || bus.peak !== ePeak || bus.bar !== eBar ||
        bus.changed !== eChg || bus.ovf !== eOvf) begin
      failures++;
      $display("[TB] FAIL %s (edge %0d): got cur=%0d peak=%0d bar=%h changed=%b ovf=%b, expected cur=%0d peak=%0d bar=%h changed=%b ovf=%b",
               name, n, bus.cur, bus.peak, bus.bar, bus.changed, bus.ovf,
               eCur, ePeak, eBar, eChg, eOvf);
    end
  endtask

  task automatic checkModel(input string name);
    int p;
    p = modelPeak(n);
    checkOutput(name, mCur, 4'(p), thermo(p), mChg, mOvf);
  endtask

  task automatic checkPeak(input string name, input logic [3:0] ePeak);
    tests++;
    if (bus.peak !== ePeak) begin
      failures++;
      $display("[TB] FAIL %s (edge %0d): got peak=%0d, expected peak=%0d", name, n, bus.peak, ePeak);
    end
  endtask

  task automatic idleSteps(input int k);
    for (int i = 0; i < k; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b0);
      checkModel("idle_step");
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.level  = 4'd7;
    bus.sample = 1'b1;

    // Reset with a competing sample, then a full hold-and-decay of level 5.
    tbl[0]  = '{1'b1, 4'd7, 1'b1, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd7, 1'b1, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'd5, 1'b1, 4'd5, 4'd5, 8'h1F, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd5, 8'h1F, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd5, 8'h1F, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd5, 8'h1F, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd5, 8'h1F, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd5, 8'h1F, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd4, 8'h0F, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd4, 8'h0F, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd3, 8'h07, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd3, 8'h07, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd2, 8'h03, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd2, 8'h03, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd1, 8'h01, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd1, 8'h01, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 8'h00, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].lvl, tbl[i].smp);
      checkOutput($sformatf("table[%0d]", i), tbl[i].eCur, tbl[i].ePeak, tbl[i].eBar,
                  tbl[i].eChg, tbl[i].eOvf);
    end

    // Re-hold: same level at edge 3 restarts the hold; lower level at edge 4 moves cur only.
    applyStimulus(1'b0, 4'd5, 1'b1);
    checkModel("rehold_e0");
    idleSteps(2);
    applyStimulus(1'b0, 4'd5, 1'b1);
    checkModel("rehold_e3");
    applyStimulus(1'b0, 4'd2, 1'b1);
    checkOutput("rehold_low", 4'd2, 4'd5, 8'h1F, 1'b1, 1'b0);
    idleSteps(4);
    checkPeak("rehold_held", 4'd5);
    idleSteps(1);
    checkPeak("rehold_drop", 4'd4);

    // Decay catch: higher level during decay re-enters hold.
    idleSteps(2);
    checkPeak("decay_to_3", 4'd3);
    applyStimulus(1'b0, 4'd6, 1'b1);
    checkOutput("catch_high", 4'd6, 4'd6, 8'h3F, 1'b1, 1'b0);
    idleSteps(5);
    checkPeak("catch_held", 4'd6);
    idleSteps(1);
    checkPeak("catch_drop", 4'd5);
    idleSteps(4);
    checkPeak("decay_to_3b", 4'd3);
    applyStimulus(1'b0, 4'd3, 1'b1);
    checkOutput("catch_equal", 4'd3, 4'd3, 8'h07, 1'b1, 1'b0);
    idleSteps(5);
    checkPeak("equal_held", 4'd3);
    idleSteps(1);
    checkPeak("equal_drop", 4'd2);

    // Clamp and overflow pulse.
    applyStimulus(1'b0, 4'd12, 1'b1);
    checkOutput("clamp", 4'd8, 4'd8, 8'hFF, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'd8, 1'b1);
    checkOutput("clamp_again", 4'd8, 4'd8, 8'hFF, 1'b0, 1'b0);

    // Mid-decay reset with peak 4 and the decay counter still running.
    idleSteps(12);
    checkPeak("pre_reset", 4'd4);
    applyStimulus(1'b1, 4'd7, 1'b1);
    checkOutput("mid_reset", 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd1, 1'b1);
    checkOutput("post_reset", 4'd1, 4'd1, 8'h01, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic s;
      logic [3:0] l;
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 2) == 0);
      l = 4'($urandom_range(0, 15));
      applyStimulus(r, l, s);
      checkModel("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
